// File: rtl/decode_ctrl_pipe.sv
// RV32I(+M) main decoder feeding the E-stage control register, with a
// small FSM that holds the E stage while a multi-cycle div/rem executes.
module decode_ctrl_pipe #(
  parameter int ENABLE_M    = 1,
  parameter int DIV_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid_d,
  input  logic [31:0] instr_d,
  input  logic        stall_e,
  input  logic        flush_e,
  output logic        reg_write_e,
  output logic        alu_src_a_e,
  output logic        mem_write_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic [2:0]  imm_src_e,
  output logic [1:0]  alu_src_b_e,
  output logic [1:0]  result_src_e,
  output logic [1:0]  arith_op_e,
  output logic        md_en_e,
  output logic [2:0]  md_op_e,
  output logic        valid_e,
  output logic        illegal_e,
  output logic        md_busy
);

  localparam int CNT_W = $clog2(DIV_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // base = {reg_write, imm_src, alu_src_a, alu_src_b, mem_write,
  //         result_src, branch, arith_op, jump}
  typedef struct packed {
    logic [13:0] base;
    logic        md_en;
    logic [2:0]  md_op;
    logic        illegal;
  } ctrl_t;

  typedef enum logic {IDLE, DIV} state_t;

  logic [6:0] opcode_p0;
  logic [6:0] funct7_p0;
  logic [2:0] funct3_p0;
  ctrl_t      dec_p0;
  ctrl_t      ctrl_p1;
  logic       vld_p1;
  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       load;
  logic       div_start;
  logic       unused_instr;

  assign opcode_p0    = instr_d[6:0];
  assign funct3_p0    = instr_d[14:12];
  assign funct7_p0    = instr_d[31:25];
  assign unused_instr = ^{instr_d[24:15], instr_d[11:7]};

  // Stage D: combinational decode
  always_comb begin
    dec_p0 = '0;
    case (opcode_p0)
      OP_R: begin
        if (funct7_p0 == 7'b0000000 || funct7_p0 == 7'b0100000) begin
          dec_p0.base = 14'b1_000_0_00_0_00_0_10_0;
        end else if (funct7_p0 == 7'b0000001 && ENABLE_M != 0) begin
          dec_p0.base  = 14'b1_000_0_00_0_00_0_10_0;
          dec_p0.md_en = 1'b1;
          dec_p0.md_op = funct3_p0;
        end else begin
          dec_p0.illegal = 1'b1;
        end
      end
      OP_IMM:    dec_p0.base = 14'b1_000_0_01_0_00_0_10_0;
      OP_LOAD:   dec_p0.base = 14'b1_000_0_01_0_01_0_00_0;
      OP_JALR:   dec_p0.base = 14'b1_000_0_01_0_10_0_00_1;
      OP_STORE:  dec_p0.base = 14'b0_001_0_01_1_00_0_00_0;
      OP_BRANCH: dec_p0.base = 14'b0_010_0_00_0_00_1_01_0;
      OP_JAL:    dec_p0.base = 14'b1_011_0_00_0_10_0_00_1;
      OP_AUIPC:  dec_p0.base = 14'b1_100_1_10_0_00_0_00_0;
      OP_LUI:    dec_p0.base = 14'b1_100_1_01_0_00_0_00_0;
      default:   dec_p0.illegal = 1'b1;
    endcase
  end

  assign md_busy   = (state_q == DIV);
  assign load      = !flush_e && !stall_e && !md_busy;
  assign div_start = load && instr_valid_d && dec_p0.md_en && dec_p0.md_op[2];

  // Stage E: control register (flush > hold > load)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (flush_e) begin
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      ctrl_p1 <= instr_valid_d ? dec_p0 : '0;
      vld_p1  <= instr_valid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Busy counter runs regardless of stall_e; only flush or reset cuts it short.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (div_start) begin
          state_d = DIV;
          cnt_d   = CNT_LOAD;
        end
      end
      DIV: begin
        if (flush_e) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign {reg_write_e, imm_src_e, alu_src_a_e, alu_src_b_e, mem_write_e,
          result_src_e, branch_e, arith_op_e, jump_e} = ctrl_p1.base;
  assign md_en_e   = ctrl_p1.md_en;
  assign md_op_e   = ctrl_p1.md_op;
  assign illegal_e = ctrl_p1.illegal;
  assign valid_e   = vld_p1;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: decode table, E-register priority,
// div busy sequencing, and an ENABLE_M=0 instance for the illegal-mul case.
module tb_decode_ctrl_pipe;

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_ILL = 32'h0000007F;
  localparam logic [31:0] I_SUB = 32'h40000033;
  localparam logic [31:0] I_BF7 = 32'h7E000033;
  localparam logic [31:0] I_MUL = 32'h022080B3;
  localparam logic [31:0] I_DIV = 32'h0220C0B3;
  localparam logic [31:0] I_LW  = 32'h00002083;
  localparam logic [31:0] I_SW  = 32'h00102023;
  localparam logic [13:0] C_R   = 14'b1_000_0_00_0_00_0_10_0;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid_d;
  logic [31:0] instr_d;
  logic        stall_e, flush_e;

  logic reg_write_e, alu_src_a_e, mem_write_e, branch_e, jump_e;
  logic [2:0] imm_src_e;
  logic [1:0] alu_src_b_e, result_src_e, arith_op_e;
  logic md_en_e, valid_e, illegal_e, md_busy;
  logic [2:0] md_op_e;

  logic n_reg_write_e, n_alu_src_a_e, n_mem_write_e, n_branch_e, n_jump_e;
  logic [2:0] n_imm_src_e;
  logic [1:0] n_alu_src_b_e, n_result_src_e, n_arith_op_e;
  logic n_md_en_e, n_valid_e, n_illegal_e, n_md_busy;
  logic [2:0] n_md_op_e;

  logic [13:0] ctrl_obs;
  assign ctrl_obs = {reg_write_e, imm_src_e, alu_src_a_e, alu_src_b_e, mem_write_e,
                     result_src_e, branch_e, arith_op_e, jump_e};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.ENABLE_M(1), .DIV_LATENCY(4)) u_dut (
    .clk(clk), .reset(reset), .instr_valid_d(instr_valid_d), .instr_d(instr_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .reg_write_e(reg_write_e), .alu_src_a_e(alu_src_a_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e), .imm_src_e(imm_src_e),
    .alu_src_b_e(alu_src_b_e), .result_src_e(result_src_e), .arith_op_e(arith_op_e),
    .md_en_e(md_en_e), .md_op_e(md_op_e), .valid_e(valid_e), .illegal_e(illegal_e),
    .md_busy(md_busy)
  );

  decode_ctrl_pipe #(.ENABLE_M(0), .DIV_LATENCY(4)) u_dut_nom (
    .clk(clk), .reset(reset), .instr_valid_d(instr_valid_d), .instr_d(instr_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .reg_write_e(n_reg_write_e), .alu_src_a_e(n_alu_src_a_e), .mem_write_e(n_mem_write_e),
    .branch_e(n_branch_e), .jump_e(n_jump_e), .imm_src_e(n_imm_src_e),
    .alu_src_b_e(n_alu_src_b_e), .result_src_e(n_result_src_e), .arith_op_e(n_arith_op_e),
    .md_en_e(n_md_en_e), .md_op_e(n_md_op_e), .valid_e(n_valid_e), .illegal_e(n_illegal_e),
    .md_busy(n_md_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    instr_valid_d = v;
    instr_d       = ins;
  endtask

  logic [6:0]  tbl_op  [9];
  logic [13:0] tbl_exp [9];

  initial begin
    tbl_op[0] = 7'b0110011; tbl_exp[0] = 14'b1_000_0_00_0_00_0_10_0;
    tbl_op[1] = 7'b0010011; tbl_exp[1] = 14'b1_000_0_01_0_00_0_10_0;
    tbl_op[2] = 7'b0000011; tbl_exp[2] = 14'b1_000_0_01_0_01_0_00_0;
    tbl_op[3] = 7'b1100111; tbl_exp[3] = 14'b1_000_0_01_0_10_0_00_1;
    tbl_op[4] = 7'b0100011; tbl_exp[4] = 14'b0_001_0_01_1_00_0_00_0;
    tbl_op[5] = 7'b1100011; tbl_exp[5] = 14'b0_010_0_00_0_00_1_01_0;
    tbl_op[6] = 7'b1101111; tbl_exp[6] = 14'b1_011_0_00_0_10_0_00_1;
    tbl_op[7] = 7'b0010111; tbl_exp[7] = 14'b1_100_1_10_0_00_0_00_0;
    tbl_op[8] = 7'b0110111; tbl_exp[8] = 14'b1_100_1_01_0_00_0_00_0;

    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    drive(1'b0, 32'h0);
    tick(); tick();
    chk("rst_valid", valid_e, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_illegal", illegal_e, 0);
    chk("rst_ctrl", ctrl_obs, 0);
    chk("rst_md_en", md_en_e, 0);

    // first edge after release loads the add
    reset = 1'b0;
    drive(1'b1, I_ADD);
    tick();
    chk("add_ctrl", ctrl_obs, C_R);
    chk("add_valid", valid_e, 1);
    chk("add_illegal", illegal_e, 0);

    drive(1'b1, I_ILL);
    tick();
    chk("ill_flag", illegal_e, 1);
    chk("ill_valid", valid_e, 1);
    chk("ill_ctl", {reg_write_e, mem_write_e, branch_e, jump_e}, 0);

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, {25'h0, tbl_op[i]});
      tick();
      chk($sformatf("dec_ctrl_%0d", i), ctrl_obs, tbl_exp[i]);
      chk($sformatf("dec_ill_%0d", i), illegal_e, 0);
    end

    drive(1'b1, I_SUB);
    tick();
    chk("sub_ctrl", ctrl_obs, C_R);
    chk("sub_ill", illegal_e, 0);

    drive(1'b1, I_BF7);
    tick();
    chk("badf7_ill", illegal_e, 1);
    chk("badf7_ctrl", ctrl_obs, 0);

    drive(1'b0, I_ADD);
    tick();
    chk("inv_valid", valid_e, 0);
    chk("inv_ctrl", ctrl_obs, 0);
    chk("inv_ill", illegal_e, 0);

    drive(1'b1, I_MUL);
    tick();
    chk("mul_md_en", md_en_e, 1);
    chk("mul_md_op", md_op_e, 0);
    chk("mul_ctrl", ctrl_obs, C_R);
    chk("mul_busy", md_busy, 0);
    chk("nom_ill", n_illegal_e, 1);
    chk("nom_md_en", n_md_en_e, 0);
    chk("nom_busy", n_md_busy, 0);
    chk("nom_rw", n_reg_write_e, 0);
    tick();
    chk("mul_busy2", md_busy, 0);
    chk("nom_busy2", n_md_busy, 0);

    // stall holds, stall+flush loads a bubble
    drive(1'b1, I_ADD);
    tick();
    stall_e = 1'b1;
    drive(1'b1, I_SW);
    tick();
    chk("stall_ctrl", ctrl_obs, C_R);
    chk("stall_valid", valid_e, 1);
    flush_e = 1'b1;
    drive(1'b1, I_LW);
    tick();
    chk("sf_valid", valid_e, 0);
    chk("sf_ctrl", ctrl_obs, 0);
    stall_e = 1'b0; flush_e = 1'b0;

    // div: 3 busy cycles, following add loads on 4th edge
    drive(1'b1, I_DIV);
    tick();
    chk("div_md_en", md_en_e, 1);
    chk("div_md_op", md_op_e, 3'b100);
    chk("div_busy1", md_busy, 1);
    drive(1'b1, I_ADD);
    tick();
    chk("div_busy2", md_busy, 1);
    chk("div_hold_op", md_op_e, 3'b100);
    tick();
    chk("div_busy3", md_busy, 1);
    tick();
    chk("div_busy_off", md_busy, 0);
    chk("div_still_held", md_en_e, 1);
    tick();
    chk("div_next_add", ctrl_obs, C_R);
    chk("div_next_md_en", md_en_e, 0);
    chk("div_next_busy", md_busy, 0);

    // flush on the second busy cycle
    drive(1'b1, I_DIV);
    tick();
    tick();
    chk("dflush_busy_pre", md_busy, 1);
    flush_e = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    chk("dflush_busy", md_busy, 0);
    chk("dflush_valid", valid_e, 0);
    flush_e = 1'b0;

    // flush on the div load edge wins
    drive(1'b1, I_DIV);
    flush_e = 1'b1;
    tick();
    chk("dload_flush_busy", md_busy, 0);
    chk("dload_flush_valid", valid_e, 0);
    flush_e = 1'b0;
    drive(1'b0, 32'h0);
    tick();

    // stall during DIV does not pause the counter
    drive(1'b1, I_DIV);
    tick();
    stall_e = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    chk("dstall_busy2", md_busy, 1);
    tick();
    chk("dstall_busy3", md_busy, 1);
    tick();
    chk("dstall_busy_off", md_busy, 0);
    chk("dstall_held", md_en_e, 1);
    stall_e = 1'b0;
    tick();
    chk("dstall_bubble", valid_e, 0);

    // back-to-back divs
    drive(1'b1, I_DIV);
    tick();
    tick();
    tick();
    tick();
    chk("b2b_gap", md_busy, 0);
    tick();
    chk("b2b_reenter", md_busy, 1);
    chk("b2b_valid", valid_e, 1);
    drive(1'b0, 32'h0);
    tick(); tick(); tick();
    chk("b2b_done", md_busy, 0);
    tick();

    // async reset mid-DIV
    drive(1'b1, I_DIV);
    tick();
    tick();
    chk("rdiv_busy_pre", md_busy, 1);
    reset = 1'b1;
    #1;
    chk("rdiv_busy", md_busy, 0);
    chk("rdiv_valid", valid_e, 0);
    chk("rdiv_md_en", md_en_e, 0);
    #1;
    reset = 1'b0;
    drive(1'b1, I_ADD);
    tick();
    chk("rdiv_post_busy", md_busy, 0);
    chk("rdiv_post_ctrl", ctrl_obs, C_R);
    chk("rdiv_post_valid", valid_e, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
